// File: rtl/poly_ram_pkg.sv
// Shared types and constants for the coefficient RAM arbiter.
package poly_ram_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
  localparam int KYBER_Q = 3329;
  localparam int N_REQ   = 2;

  // One requester's access as seen by the RAM.
  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/poly_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant logic with the last-grant register.
// With POLY_ARB_LOCK_EN defined, a beat carrying lock=1 pins the grant
// to its port until that port issues a beat with lock=0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  logic       last_grant;
  logic [1:0] rr_gnt;
  logic       gidx;

  assign gidx = gnt[1];

  // Plain alternation: a tie goes to the port that was not granted last.
  always_comb begin
    rr_gnt = 2'b00;
    case (valid)
      2'b01:   rr_gnt = 2'b01;
      2'b10:   rr_gnt = 2'b10;
      2'b11:   rr_gnt = last_grant ? 2'b01 : 2'b10;
      default: rr_gnt = 2'b00;
    endcase
  end

`ifdef POLY_ARB_LOCK_EN
  logic lock_act;
  logic lock_owner;

  // While locked only the owner may be granted, idle or not.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (lock_act) gnt[lock_owner] = valid[lock_owner];
      else          gnt = rr_gnt;
    end
  end

  // Lock state follows the lock flag of every accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_act   <= 1'b0;
      lock_owner <= 1'b0;
    end else if (|gnt) begin
      lock_act   <= lock[gidx];
      lock_owner <= gidx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;

  // No lock: grant straight from the round-robin choice.
  always_comb begin
    gnt = 2'b00;
    if (!rst) gnt = rr_gnt;
  end
`endif

  // Remember the winner; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst)        last_grant <= 1'b1;
    else if (|gnt)  last_grant <= gidx;
  end

endmodule

// File: rtl/poly_ram_arbiter.sv
// Round-robin arbiter in front of the single-port no-change coefficient RAM.
// Port 0: coefficient load/store engine. Port 1: poly-mult/NTT engine.
// Optional burst lock enabled by defining POLY_ARB_LOCK_EN.
module poly_ram_arbiter
  import poly_ram_pkg::*;
#(
  parameter int ADDR_W = poly_ram_pkg::ADDR_W,
  parameter int DATA_W = poly_ram_pkg::DATA_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0]               req_we,
  input  logic [N_REQ-1:0]               req_lock,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_di,
  input  logic [DATA_W-1:0]              ram_dout
);

  logic [1:0] gnt;
  logic       gidx;
  logic       beat;
  logic       rd_pend;
  logic       rd_tag;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .lock  (req_lock),
    .gnt   (gnt)
  );

  assign gidx      = gnt[1];
  assign beat      = |gnt;
  assign req_ready = gnt;

  // Route the granted request onto the RAM port; idle drives zeros.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (beat) begin
      ram_en   = 1'b1;
      ram_we   = req_we[gidx];
      ram_addr = req_addr[gidx];
      ram_di   = req_wdata[gidx];
    end
  end

  // Track the read in flight; a write leaves ram_dout stale, so it clears rd_pend.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= beat & ~req_we[gidx];
      if (beat & ~req_we[gidx]) rd_tag <= gidx;
    end
  end

  // A read issued just before reset is dropped rather than delivered during reset.
  assign rsp_valid = {rd_pend & ~rst & rd_tag, rd_pend & ~rst & ~rd_tag};
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_poly_ram_arbiter.sv
// Directed self-checking bench for poly_ram_arbiter with a behavioural
// no-change single-port RAM attached.
module tb_poly_ram_arbiter;
  import poly_ram_pkg::*;

  logic                         clk;
  logic                         rst;
  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0]             req_ready;
  logic [N_REQ-1:0]             req_we;
  logic [N_REQ-1:0]             req_lock;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         ram_en;
  logic                         ram_we;
  logic [ADDR_W-1:0]            ram_addr;
  logic [DATA_W-1:0]            ram_di;
  logic [DATA_W-1:0]            ram_dout;

  logic [DATA_W-1:0] mem [128];

  int n_cmp;
  int n_err;

  poly_ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_dout  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // No-change RAM: dout updates only on reads.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc;
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v, input ram_req_t r);
    req_valid[p] = v;
    req_we[p]    = r.we;
    req_lock[p]  = r.lock;
    req_addr[p]  = r.addr;
    req_wdata[p] = r.wdata;
  endtask

  task automatic idle_all;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    ram_dout = '0;
    rst      = 1'b1;
    idle_all();

    // Reset: requests present but nothing granted.
    next_cyc();
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd1, wdata:16'd0});
    set_req(1, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd2, wdata:16'd0});
    mid_cyc();
    check_val("rst_ready", req_ready, 2'b00);
    check_val("rst_ram_en", ram_en, 1'b0);
    check_val("rst_ram_we", ram_we, 1'b0);
    check_val("rst_rsp_valid", rsp_valid, 2'b00);

    // Write 0x0D00 to addr 5 via port 0, then read it back.
    next_cyc();
    rst = 1'b0;
    idle_all();
    set_req(0, 1'b1, '{we:1'b1, lock:1'b0, addr:7'd5, wdata:16'h0D00});
    mid_cyc();
    check_val("wr5_ready", req_ready, 2'b01);
    check_val("wr5_en", ram_en, 1'b1);
    check_val("wr5_we", ram_we, 1'b1);
    check_val("wr5_addr", ram_addr, 7'd5);
    check_val("wr5_di", ram_di, 16'h0D00);
    next_cyc();
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd5, wdata:16'h0});
    mid_cyc();
    check_val("rd5_we", ram_we, 1'b0);
    check_val("rd5_no_rsp_after_wr", rsp_valid, 2'b00);
    next_cyc();
    idle_all();
    mid_cyc();
    check_val("rd5_rsp_valid", rsp_valid, 2'b01);
    check_val("rd5_rdata", rsp_rdata, 16'h0D00);

    // Preload addr 0..3 and 64..67 with their own address through port 1.
    for (int i = 0; i < 8; i++) begin
      next_cyc();
      set_req(1, 1'b1, '{we:1'b1, lock:1'b0,
                         addr:7'((i < 4) ? i : 60 + i),
                         wdata:16'((i < 4) ? i : 60 + i)});
      mid_cyc();
      check_val("preload_ready", req_ready, 2'b10);
    end

    // Both ports read continuously: grants alternate from port 0.
    for (int k = 0; k < 8; k++) begin
      next_cyc();
      set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'((k + 1) / 2), wdata:16'h0});
      set_req(1, 1'b1, '{we:1'b0, lock:1'b0, addr:7'(64 + k / 2), wdata:16'h0});
      mid_cyc();
      check_val("alt_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) begin
        check_val("alt_rsp_valid", rsp_valid, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
        check_val("alt_rdata", rsp_rdata, ((k - 1) % 2 == 0) ? k / 2 : 64 + (k - 1) / 2);
      end
    end
    next_cyc();
    idle_all();
    mid_cyc();
    check_val("alt_last_rsp_valid", rsp_valid, 2'b10);
    check_val("alt_last_rdata", rsp_rdata, 16'd67);

    // Port 1 alone for 10 cycles, then port 0 joins and wins.
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      set_req(1, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd64, wdata:16'h0});
      mid_cyc();
      check_val("solo1_ready", req_ready, 2'b10);
    end
    next_cyc();
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd0, wdata:16'h0});
    mid_cyc();
    check_val("join0_ready", req_ready, 2'b01);

    // Read-after-write of q-1 at addr 10.
    next_cyc();
    idle_all();
    set_req(0, 1'b1, '{we:1'b1, lock:1'b0, addr:7'd10, wdata:16'(KYBER_Q - 1)});
    next_cyc();
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd10, wdata:16'h0});
    mid_cyc();
    check_val("raw_no_rsp_after_wr", rsp_valid, 2'b00);
    next_cyc();
    idle_all();
    mid_cyc();
    check_val("raw_rsp_valid", rsp_valid, 2'b01);
    check_val("raw_rdata", rsp_rdata, 16'd3328);

    // Read accepted, then reset on the following cycle drops the response.
    next_cyc();
    set_req(1, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd64, wdata:16'h0});
    mid_cyc();
    check_val("pre_rst_ready", req_ready, 2'b10);
    next_cyc();
    rst = 1'b1;
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd0, wdata:16'h0});
    mid_cyc();
    check_val("mid_rst_rsp_valid", rsp_valid, 2'b00);
    check_val("mid_rst_ready", req_ready, 2'b00);
    check_val("mid_rst_ram_en", ram_en, 1'b0);
    next_cyc();
    rst = 1'b0;
    mid_cyc();
    check_val("post_rst_rsp_valid", rsp_valid, 2'b00);
    check_val("post_rst_tie_ready", req_ready, 2'b01);
    next_cyc();
    idle_all();
    mid_cyc();
    check_val("post_rst_rd_valid", rsp_valid, 2'b01);
    check_val("post_rst_rd_data", rsp_rdata, 16'd0);

`ifdef POLY_ARB_LOCK_EN
    // Port 1 locked burst of 128 reads with port 0 waiting throughout.
    for (int i = 0; i < 128; i++) begin
      next_cyc();
      set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd1, wdata:16'h0});
      set_req(1, 1'b1, '{we:1'b0, lock:(i < 127), addr:7'(i), wdata:16'h0});
      mid_cyc();
      check_val("burst_ready", req_ready, 2'b10);
    end
    next_cyc();
    set_req(1, 1'b0, '0);
    mid_cyc();
    check_val("burst_release_ready", req_ready, 2'b01);
`else
    // Without the lock feature req_lock is ignored: ties still alternate.
    next_cyc();
    set_req(0, 1'b1, '{we:1'b0, lock:1'b0, addr:7'd1, wdata:16'h0});
    set_req(1, 1'b1, '{we:1'b0, lock:1'b1, addr:7'd2, wdata:16'h0});
    mid_cyc();
    check_val("nolock_first_ready", req_ready, 2'b10);
    next_cyc();
    mid_cyc();
    check_val("nolock_second_ready", req_ready, 2'b01);
`endif

    next_cyc();
    idle_all();
    next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/poly_ram_arbiter.md
# poly_ram_arbiter

Two-port round-robin arbiter in front of the single-port, no-change coefficient RAM `rams_sp_nc` (128 × 16-bit) in the polynomial-multiplication datapath. Requester 0 is the coefficient load/store engine and requester 1 is the poly-mult/NTT engine. The block grants at most one RAM access per cycle and routes read data back to the requester that issued the read. It sustains one access per cycle with no bubbles, and includes an optional burst-lock feature.

## Interface
Parameters:
- ADDR_W, 7, RAM address width (128 words)
- DATA_W, 16, RAM word width (12-bit coefficient mod 3329, zero-extended)

Ports:
- clk  in  1  single clock; RAM shares it
- rst  in  1  synchronous, active-high reset
- req_valid  in  [2]  per-requester access request
- req_ready  out  [2]  request accepted this cycle (valid&ready = beat)
- req_we  in  [2]  1 = write, 0 = read
- req_lock  in  [2]  hold grant after this beat (used only with POLY_ARB_LOCK_EN)
- req_addr  in  [2][ADDR_W]  word address
- req_wdata  in  [2][DATA_W]  write data
- rsp_valid  out  [2]  read data valid for that requester
- rsp_rdata  out  [DATA_W]  read data, shared bus, qualified by rsp_valid
- ram_en, ram_we  out  1  to RAM en/we
- ram_addr  out  ADDR_W  to RAM addr
- ram_di  out  DATA_W  to RAM di
- ram_dout  in  DATA_W  from RAM dout; valid one cycle after a read enable

## Operation
- State: `last_grant` (1 bit), `rd_pend` (1 bit), `rd_tag` (1 bit). `lock_act` and `lock_owner` exist only with the lock macro.
- Arbitration is combinational each cycle.
  - Exactly one req_valid → that port is granted.
  - Both valid → port != last_grant is granted (alternation).
  - None valid → no grant. ram_en=0, ram_we=0, addr/di are don't-care but driven 0.
- Grant → req_ready[g]=1, ram_en=1, ram_we=req_we[g], ram_addr=req_addr[g], ram_di=req_wdata[g]. On the clock edge, last_grant←g.
- Read beat → rd_pend←1, rd_tag←g. Write beat or no beat → rd_pend←0.
- rsp_valid[i] = rd_pend && rd_tag==i. rsp_rdata = ram_dout, passed combinationally.
- Writes produce no response. Because the RAM is no-change, the next cycle's ram_dout is stale and must not be flagged.
- No response backpressure. Requesters must always accept rsp_valid.
- During rst: req_ready=0, ram_en=0, ram_we=0.
- On the edge where rst is sampled high: last_grant←1 (port 0 wins the first tie), rd_pend←0, lock cleared. A read pending when reset asserts is dropped, so rsp_valid=0 in the cycle after reset.

## Timing
- Request to RAM: 0 cycles. A beat in cycle N drives the RAM in cycle N.
- Read latency: rsp_valid in cycle N+1.
- Throughput: 1 beat/cycle total. Back-to-back reads from alternating ports give alternating rsp_valid with no gaps.
- Read-after-write to the same address on consecutive cycles returns the new data (RAM write completes at edge N).
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.

## Configuration
- `POLY_ARB_LOCK_EN` defined:
  - A beat accepted with req_lock[g]=1 sets lock_act←1, lock_owner←g.
  - While lock_act=1, only lock_owner can be granted, even if it idles. The other port sees req_ready=0.
  - A beat from the owner with req_lock=0 clears lock_act after that beat.
  - Used for uninterrupted 128-word polynomial bursts.
- Undefined: req_lock is ignored and the lock registers are absent. Pure round-robin.

## Structure
- Package `poly_ram_pkg`:
  - ADDR_W, DATA_W, KYBER_Q=3329, N_REQ=2
  - `ram_req_t` struct {we, lock, addr, wdata}
- One sub-module, `rr_arb2`: 2-way round-robin grant logic plus the last_grant register (and lock state under the macro). The top level handles the RAM mux and response tagging.

## Test plan
- Reset, then port 0 writes addr 5 = 16'h0D00 → ram_en=1, ram_we=1, ram_addr=5 the same cycle. A port 0 read of addr 5 the next cycle gives rsp_valid[0]=1, rsp_rdata=16'h0D00 one cycle later. rsp_valid[1] stays 0.
- Both ports read continuously, port 0 addr 0..3 and port 1 addr 64..67 (preloaded with the index value) → grants alternate 0,1,0,1 starting with port 0. Responses alternate with correct data and no idle cycles.
- Only port 1 valid for 10 cycles → granted every cycle. Port 0 then joins → port 0 is granted next.
- Write addr 10 = 3328, then read addr 10 on the next cycle → the read returns 3328. No rsp_valid in the cycle after the write.
- Read accepted, rst asserted in the following cycle → rsp_valid=0 and req_ready=0 during reset. After reset, a tie grants port 0.
- `POLY_ARB_LOCK_EN`: port 1 bursts 128 reads with lock=1 except the last beat, while port 0 is valid throughout → port 0 ready=0 for the whole burst and is granted on the cycle after the final unlocked beat.
